// File: rtl/adder.sv
// 32-bit two-level carry-lookahead adder with registered sum and carries into/out of bit 31.
// Eight 4-bit lookahead groups feed a flat second-level lookahead unit; there is no ripple between groups.
module adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inp1,
  input  logic [31:0] inp2,
  output logic [31:0] out,
  output logic        c31,
  output logic        c32
);

  logic [31:0] g;
  logic [31:0] p;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [32:0] carry;
  logic [31:0] sum;

  logic [31:0] out_q, out_d;
  logic        c31_q, c31_d;
  logic        c32_q, c32_d;

  always_comb begin
    logic term;
    logic prod;
    g     = inp1 & inp2;
    p     = inp1 ^ inp2;
    grp_g = '0;
    grp_p = '0;
    carry = '0;
    term  = 1'b0;
    prod  = 1'b0;

    for (int k = 0; k < 8; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end

    // Second level: each group carry-in is a flat sum of products of G/P (carry into bit 0 is 0).
    for (int k = 1; k <= 8; k++) begin
      term = 1'b0;
      for (int j = 0; j < k; j++) begin
        prod = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          prod = prod & grp_p[m];
        end
        term = term | prod;
      end
      carry[4*k] = term;
    end

    for (int k = 0; k < 8; k++) begin
      carry[4*k+1] = g[4*k] | (p[4*k] & carry[4*k]);
      carry[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                   | (p[4*k+1] & p[4*k] & carry[4*k]);
      carry[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                   | (p[4*k+2] & p[4*k+1] & g[4*k])
                   | (p[4*k+2] & p[4*k+1] & p[4*k] & carry[4*k]);
    end

    sum   = p ^ carry[31:0];
    out_d = sum;
    c31_d = carry[31];
    c32_d = carry[32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      c31_q <= 1'b0;
      c32_q <= 1'b0;
    end else begin
      out_q <= out_d;
      c31_q <= c31_d;
      c32_q <= c32_d;
    end
  end

  assign out = out_q;
  assign c31 = c31_q;
  assign c32 = c32_q;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: expected results are queued as operands are driven and
// popped when the registered result is sampled one edge later.
module tb_adder;

  logic        clk;
  logic        rst;
  logic [31:0] inp1;
  logic [31:0] inp2;
  logic [31:0] out;
  logic        c31;
  logic        c32;

  typedef struct {
    string       tag;
    logic [31:0] sum;
    logic        c31;
    logic        c32;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  adder dut (
    .clk  (clk),
    .rst  (rst),
    .inp1 (inp1),
    .inp2 (inp2),
    .out  (out),
    .c31  (c31),
    .c32  (c32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  // Reference model: 33-bit sum for out/c32, 31-bit sum for the carry into bit 31.
  function automatic exp_t model(input string tag, input logic [31:0] a,
                                 input logic [31:0] b, input logic r);
    exp_t        e;
    logic [32:0] s33;
    logic [31:0] s31;
    s33   = {1'b0, a} + {1'b0, b};
    s31   = {1'b0, a[30:0]} + {1'b0, b[30:0]};
    e.tag = tag;
    e.sum = r ? 32'h0 : s33[31:0];
    e.c31 = r ? 1'b0 : s31[31];
    e.c32 = r ? 1'b0 : s33[32];
    return e;
  endfunction

  // Drive one operand pair (optionally with reset) and check the result after the edge.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic r);
    exp_t e;
    @(negedge clk);
    inp1 = a;
    inp2 = b;
    rst  = r;
    exp_q.push_back(model(tag, a, b, r));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_out"}, out, e.sum);
      chk({e.tag, "_c31"}, {31'd0, c31}, {31'd0, e.c31});
      chk({e.tag, "_c32"}, {31'd0, c32}, {31'd0, e.c32});
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    inp1 = 32'h0;
    inp2 = 32'h0;

    step("reset", 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1);
    step("zero", 32'h0, 32'h0, 1'b0);
    step("pos_ovf", 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
    step("full_carry", 32'hFFFFFFFF, 32'h00000001, 1'b0);
    step("neg_ovf", 32'h80000000, 32'h80000000, 1'b0);

    // Back-to-back pairs with a one-cycle reset in the middle.
    step("b2b0", 32'h12345678, 32'h11111111, 1'b0);
    step("b2b1", 32'hFFFF0000, 32'h00010000, 1'b0);
    step("b2b_rst", 32'h7FFFFFFF, 32'h00000001, 1'b1);
    step("b2b2", 32'h7FFFFFFF, 32'h00000001, 1'b0);
    step("b2b3", 32'hAAAAAAAA, 32'h55555555, 1'b0);

    // Carry across every 4-bit group boundary and every single bit.
    for (int i = 0; i < 8; i++) begin
      a = 32'hFFFFFFFF >> (28 - 4 * i);
      step("grp_bound", a, 32'h1, 1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      a = 32'h1 << i;
      step("bit_walk", a, a, 1'b0);
    end

    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      b = $urandom;
      case (i % 4)
        0: b = ~a;
        1: b = 32'h1;
        default: ;
      endcase
      step("rand", a, b, 1'b0);
    end

    chk("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
